// File: rtl/jk_sync_counter.sv
// Synchronous modulo-MODULUS up/down counter built from per-bit JK excitation.
// Priority at each rising edge: load (clamped to MODULUS-1) > count > hold.
// Define JK_EXC_OUT_EN to expose the internal J/K excitation vectors as ports.
module jk_sync_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             EN,
    input  logic             UP,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
`ifdef JK_EXC_OUT_EN
    output logic [WIDTH-1:0] J_exc,
    output logic [WIDTH-1:0] K_exc,
`endif
    output logic             TC
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    // Next-state selection; wrap uses compares so any modulus works and out-of-range states recover
    always_comb begin
        nxt = Q;
        if (LD) begin
            nxt = (D > MAX_VAL) ? MAX_VAL : D;
        end else if (EN) begin
            if (UP) begin
                nxt = (Q >= MAX_VAL) ? '0 : Q + WIDTH'(1);
            end else begin
                nxt = ((Q == '0) || (Q > MAX_VAL)) ? MAX_VAL : Q - WIDTH'(1);
            end
        end
    end

    // JK excitation derived from current and next state; never produces toggle
    always_comb begin
        j = nxt & ~Q;
        k = ~nxt & Q;
    end

    // Per-bit JK flip-flops with asynchronous clear
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            Q <= '0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                case ({j[i], k[i]})
                    2'b10:   Q[i] <= 1'b1;
                    2'b01:   Q[i] <= 1'b0;
                    2'b11:   Q[i] <= ~Q[i];
                    default: Q[i] <= Q[i];
                endcase
            end
        end
    end

    // Complement output and combinational terminal count, gated off during clear
    always_comb begin
        Q_bar = ~Q;
        TC    = CLR & EN & ~LD & ((UP & (Q == MAX_VAL)) | (~UP & (Q == '0)));
    end

`ifdef JK_EXC_OUT_EN
    // Exported excitation is quiet during clear and when neither loading nor counting
    always_comb begin
        J_exc = (CLR && (EN || LD)) ? j : '0;
        K_exc = (CLR && (EN || LD)) ? k : '0;
    end
`endif

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed self-checking bench for jk_sync_counter (MODULUS=10, WIDTH=4).
module tb_jk_sync_counter;

    logic       CLK = 1'b0;
    logic       CLR;
    logic       EN;
    logic       UP;
    logic       LD;
    logic [3:0] D;
    logic [3:0] Q;
    logic [3:0] Q_bar;
    logic       TC;
`ifdef JK_EXC_OUT_EN
    logic [3:0] J_exc;
    logic [3:0] K_exc;
`endif

    int n_pass = 0;
    int n_total = 0;

    jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .EN    (EN),
        .UP    (UP),
        .LD    (LD),
        .D     (D),
        .Q     (Q),
        .Q_bar (Q_bar),
`ifdef JK_EXC_OUT_EN
        .J_exc (J_exc),
        .K_exc (K_exc),
`endif
        .TC    (TC)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic load(input logic [3:0] val);
        LD = 1'b1;
        D  = val;
        step();
        LD = 1'b0;
    endtask

`ifdef JK_EXC_OUT_EN
    // Excitation must never request a toggle
    always @(negedge CLK) begin
        if (CLR === 1'b1) chk("jk_disjoint", 32'(J_exc & K_exc), 32'd0);
    end
`endif

    initial begin
        CLR = 1'b0; EN = 1'b1; UP = 1'b0; LD = 1'b0; D = 4'd0;
        @(negedge CLK);
        chk("rst_q", 32'(Q), 32'd0);
        chk("rst_qbar", 32'(Q_bar), 32'hF);
        chk("rst_tc", 32'(TC), 32'd0);

        // Release clear, count up once
        CLR = 1'b1; UP = 1'b1;
        step();
        chk("rel_q", 32'(Q), 32'd1);

        // Up count across the wrap
        load(4'd0);
        chk("ld0_q", 32'(Q), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            chk("up_tc", 32'(TC), 32'(i == 10));
            step();
            chk("up_q", 32'(Q), 32'(i % 10));
        end
        chk("up_qbar", 32'(Q_bar), 32'hF);

        // Asynchronous clear mid-cycle
        load(4'd7);
        chk("ld7_q", 32'(Q), 32'd7);
        #2 CLR = 1'b0;
        #1;
        chk("aclr_q", 32'(Q), 32'd0);
        chk("aclr_qbar", 32'(Q_bar), 32'hF);
        chk("aclr_tc", 32'(TC), 32'd0);
        @(negedge CLK);
        chk("aclr_hold", 32'(Q), 32'd0);
        CLR = 1'b1;

        // Down count across the wrap
        load(4'd2);
        UP = 1'b0;
        step();
        chk("dn_q1", 32'(Q), 32'd1);
        chk("dn_tc1", 32'(TC), 32'd0);
        step();
        chk("dn_q0", 32'(Q), 32'd0);
        chk("dn_tc0", 32'(TC), 32'd1);
        step();
        chk("dn_q9", 32'(Q), 32'd9);

        // Load with count enabled, then clamped load
        UP = 1'b1; EN = 1'b1;
        load(4'd6);
        chk("ld6_q", 32'(Q), 32'd6);
        LD = 1'b1; D = 4'd13;
        step();
        chk("clamp_q", 32'(Q), 32'd9);
        #1;
        chk("tc_ld_mask", 32'(TC), 32'd0);
        LD = 1'b0;
        #1;
        chk("tc_zero_lat", 32'(TC), 32'd1);

        // Hold then direction change
        @(negedge CLK);
        load(4'd5);
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_q", 32'(Q), 32'd5);
            chk("hold_tc", 32'(TC), 32'd0);
        end
        EN = 1'b1; UP = 1'b1;
        step();
        chk("dir_up", 32'(Q), 32'd6);
        UP = 1'b0;
        step();
        chk("dir_dn", 32'(Q), 32'd5);
        chk("dir_qbar", 32'(Q_bar), 32'hA);

`ifdef JK_EXC_OUT_EN
        load(4'd7);
        UP = 1'b1; EN = 1'b1;
        #1;
        chk("j_exc", 32'(J_exc), 32'h8);
        chk("k_exc", 32'(K_exc), 32'h7);
        EN = 1'b0;
        #1;
        chk("j_idle", 32'(J_exc), 32'h0);
        chk("k_idle", 32'(K_exc), 32'h0);
        @(negedge CLK);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
Name: jk_sync_counter

Overview:
- Synchronous modulo-N up/down counter built from per-bit JK excitation logic.
- Each bit computes J/K from the current and next state and updates by the JK rule (hold, set, reset, toggle).
- Consumes the JK flip-flop behaviour downstream; this is the first multi-bit sequential stage built on it.
- TC output cascades into further counter stages.

Parameters:
- WIDTH, 4, counter bit width; must satisfy 2^WIDTH >= MODULUS.
- MODULUS, 10, count range 0..MODULUS-1; must be >= 2.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- CLR  input  1  asynchronous active-low reset.
- EN  input  1  count enable.
- UP  input  1  direction; 1 = up, 0 = down.
- LD  input  1  synchronous load strobe.
- D  input  WIDTH  load value.
- Q  output  WIDTH  counter state, registered.
- Q_bar  output  WIDTH  bitwise complement of Q.
- TC  output  1  terminal count, combinational.

Behaviour:
- Reset:
  - CLR low forces Q=0 and Q_bar=all-ones immediately, without waiting for CLK.
  - Held while CLR low; LD, EN and UP are ignored.
  - First update occurs on the first rising CLK edge after CLR returns high.
- Priority at each rising edge (CLR high): LD > EN > hold.
- LD=1:
  - Q <= D when D < MODULUS.
  - Q <= MODULUS-1 when D >= MODULUS (clamped).
  - EN and UP are ignored that cycle.
- LD=0, EN=1, UP=1: Q <= Q+1; Q=MODULUS-1 wraps to 0.
- LD=0, EN=1, UP=0: Q <= Q-1; Q=0 wraps to MODULUS-1.
- LD=0, EN=0: Q holds.
- Next-state arithmetic is WIDTH bits wide, no carry out.
- Wrap detection uses compare against MODULUS-1 or 0, not natural overflow, so non-power-of-2 moduli work.
- Per-bit excitation, with N = computed next state and C = current Q:
  - J[i] = N[i] & ~C[i]
  - K[i] = ~N[i] & C[i]
  - Bit update follows the JK table: 00 hold, 10 set, 01 reset, 11 toggle.
  - Output Q must equal N every cycle.
- TC = EN & ~LD & ((UP & Q==MODULUS-1) | (~UP & Q==0)).
  - Combinational; asserts the cycle before wrap.
  - Forced 0 while CLR low.
- Q_bar is always ~Q, including during reset.
- Latency:
  - Q reflects a LD or count one edge after the inputs are sampled.
  - TC reflects the current Q and inputs with zero latency.
- Simultaneous events:
  - CLR asserted mid-cycle overrides any pending LD or count.
  - CLR released coincident with a CLK edge: that edge is ignored; Q stays 0.
  - UP toggled while EN=1 takes effect on the next edge, from the current Q, with no extra step.
- Out-of-range Q (unreachable except by X-propagation): next count treats it as wrap and loads 0 (up) or MODULUS-1 (down).

Optional Feature:
- Macro: JK_EXC_OUT_EN.
- With the macro defined, two extra output ports are added:
  - J_exc, output, WIDTH: internal J vector.
  - K_exc, output, WIDTH: internal K vector.
  - Both are combinational and reflect the excitation for the upcoming edge.
  - Both are 0 when CLR low, or when EN=0 and LD=0.
  - J_exc & K_exc is always 0, because the encoding never uses toggle.
- Without the macro: ports absent; J/K remain internal nets; Q, Q_bar and TC behaviour is identical.

Test Plan:
- Reset: CLR=0 mid-count at Q=7 -> Q=0 and Q_bar=4'hF before the next CLK edge; CLR=1 with EN=1, UP=1 -> Q=1 after the first edge.
- Up wrap: MODULUS=10, EN=1, UP=1 from Q=0 over 10 edges -> Q sequence 1..9,0; TC=1 only while Q=9.
- Down wrap: EN=1, UP=0 from Q=2 -> Q=1, then 0 (TC=1), then 9.
- Load: LD=1, D=4'd6, EN=1 -> Q=6 next edge with no count that cycle; LD=1, D=4'd13 -> Q=9 (clamp).
- Hold and direction change: EN=0 at Q=5 for 3 edges -> Q=5, TC=0; then EN=1, UP toggled 1->0 between edges -> Q 6,5.
- JK_EXC_OUT_EN build: Q=4'b0111, UP=1, EN=1 -> J_exc=4'b1000, K_exc=4'b0111; J_exc & K_exc == 0 checked every cycle.
